// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit between the CPU datapath and a 32 x 32-bit word data RAM.
// Byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests become word RAM cycles;
// sub-word stores use a read-modify-write (RD, WAIT, WR), and loads are
// returned sign- or zero-extended with a one-cycle done pulse.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   req/ready          request strobe, accepted only while ready=1 (IDLE)
//   we, size, sign_ext request kind: store/load, 00 B / 01 H / 10 W / 11 bad
//   addr, wdata        byte address (word addr[6:2], lane addr[1:0]), store data
//   done, err, rdata   completion pulse, reject flag, held load result
//   ram_*              word RAM port (registered read data on ram_rdata)
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// requests with err=1; otherwise they are silently aligned.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ram_ena,
  output logic        ram_wena,
  output logic [4:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t      state_r, next_state_s;
  logic        we_r, sign_r;
  logic [1:0]  size_r;
  logic [6:0]  addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        ready_r, done_r, err_r;
  logic        ram_ena_r, ram_wena_r;
  logic [4:0]  ram_addr_r;
  logic [31:0] ram_wdata_r;
  logic        reject_s;
  logic [6:0]  acc_addr_s;
  logic        ram_ena_s, ram_wena_s;
  logic [4:0]  ram_addr_s;
  logic [31:0] ram_wdata_s;

  // Force the natural alignment of the access size.
  function automatic logic [6:0] align_addr(input logic [1:0] sz, input logic [6:0] a);
    case (sz)
      2'b01:   return {a[6:1], 1'b0};
      2'b10:   return {a[6:2], 2'b00};
      default: return a;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b01:   return lane[0];
      2'b10:   return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Pick the addressed lane (little-endian) and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   return {{24{sx & b[7]}}, b};
      2'b01:   return {{16{sx & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed lane of the old word with right-justified store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (sz)
      2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) begin
          m[31:16] = wd[15:0];
        end else begin
          m[15:0] = wd[15:0];
        end
      end
      default: m = wd;
    endcase
    return m;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject_s = (size == 2'b11) | is_misaligned(size, addr[1:0]);
`else
  assign reject_s = (size == 2'b11);
`endif

  // While accepting, the RAM address comes from the request being latched.
  assign acc_addr_s = (state_r == ST_IDLE) ? align_addr(size, addr) : addr_r;

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          if (reject_s) begin
            next_state_s = ST_RESP;
          end else if (we && (size == 2'b10)) begin
            next_state_s = ST_WR;
          end else begin
            next_state_s = ST_RD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD:   next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (we_r) begin
          next_state_s = ST_WR;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      ST_WR:   next_state_s = ST_RESP;
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // RAM port values for the state being entered; registered below so the
  // port is a clean function of the current state. The merge uses the read
  // word straight off ram_rdata during WAIT, so no separate buffer is kept.
  always_comb begin
    ram_ena_s   = 1'b0;
    ram_wena_s  = 1'b0;
    ram_addr_s  = 5'd0;
    ram_wdata_s = 32'd0;
    case (next_state_s)
      ST_RD: begin
        ram_ena_s  = 1'b1;
        ram_addr_s = acc_addr_s[6:2];
      end
      ST_WR: begin
        ram_ena_s  = 1'b1;
        ram_wena_s = 1'b1;
        ram_addr_s = acc_addr_s[6:2];
        if (state_r == ST_IDLE) begin
          ram_wdata_s = wdata;
        end else begin
          ram_wdata_s = store_merge(ram_rdata, wdata_r, size_r, addr_r[1:0]);
        end
      end
      default: begin
        ram_ena_s   = 1'b0;
        ram_wena_s  = 1'b0;
        ram_addr_s  = 5'd0;
        ram_wdata_s = 32'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Latch the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sign_r  <= 1'b0;
      addr_r  <= 7'd0;
      wdata_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && req) begin
      we_r    <= we;
      size_r  <= size;
      sign_r  <= sign_ext;
      addr_r  <= align_addr(size, addr);
      wdata_r <= wdata;
    end
  end

  // Load result; stores and rejected requests leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if ((state_r == ST_WAIT) && !we_r) begin
      rdata_r <= load_extract(ram_rdata, size_r, addr_r[1:0], sign_r);
    end
  end

  // Registered handshake and RAM outputs; reset clears them asynchronously,
  // which also aborts a write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ram_ena_r   <= 1'b0;
      ram_wena_r  <= 1'b0;
      ram_addr_r  <= 5'd0;
      ram_wdata_r <= 32'd0;
    end else begin
      ready_r     <= (next_state_s == ST_IDLE);
      done_r      <= (next_state_s == ST_RESP);
      err_r       <= (state_r == ST_IDLE) && (next_state_s == ST_RESP);
      ram_ena_r   <= ram_ena_s;
      ram_wena_r  <= ram_wena_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign ram_ena   = ram_ena_r;
  assign ram_wena  = ram_wena_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a vector table of requests with
// expected result, latency and RAM activity, plus hand-written sequences for
// reset during a write and a request presented while busy.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        ready, done, err;
  logic [31:0] rdata;
  logic        ram_ena, ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        preload;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM model with registered read data, plus activity counters.
  logic [31:0] mem [0:31];
  int          ena_count   = 0;
  int          wr_count    = 0;
  int          done_count  = 0;
  int          addr1_count = 0;
  logic [4:0]  last_waddr  = 5'd0;
  logic [31:0] last_wdata  = 32'd0;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'h11112222;
      3:       return 32'h12345678;
      4:       return 32'hCAFEF00D;
      default: return 32'h00000000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else begin
      if (done) done_count <= done_count + 1;
      if (ram_ena) begin
        ena_count <= ena_count + 1;
        if (ram_addr == 5'd1) addr1_count <= addr1_count + 1;
        if (ram_wena) begin
          mem[ram_addr] <= ram_wdata;
          wr_count      <= wr_count + 1;
          last_waddr    <= ram_addr;
          last_wdata    <= ram_wdata;
        end else begin
          ram_rdata <= mem[ram_addr];
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ena;
    logic        exp_wr;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [6:0] a, input logic [31:0] wd, input logic [31:0] erd,
                     input logic eerr, input int elat, input int eena, input logic ewr,
                     input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.we = w; v.size = sz; v.sx = sx; v.addr = a; v.wdata = wd;
    v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat; v.exp_ena = eena;
    v.exp_wr = ewr; v.exp_waddr = ewa; v.exp_wdata = ewd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Wait for ready, present the request for one edge, then scramble the
  // inputs and count cycles until done (lat=0 means done never came).
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx, input logic [6:0] a,
                       input logic [31:0] wd, output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; size = 2'($urandom); sign_ext = ~sx;
    addr = 7'($urandom); wdata = $urandom;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, ena0, wr0, done0, a10;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; preload = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
    sign_ext = 1'b0; addr = 7'd0; wdata = 32'd0;

    // name       we    size   sx    addr   wdata          rdata          err  lat ena wr  waddr wdata
    add("sw08",   1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 1'b1, 5'd2, 32'hDEADBEEF);
    add("lw08",   1'b0, 2'b10, 1'b0, 7'h08, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("sb09",   1'b1, 2'b00, 1'b0, 7'h09, 32'h00000055, 32'hDEADBEEF, 1'b0, 4, 2, 1'b1, 5'd2, 32'hDEAD55EF);
    add("lbu09",  1'b0, 2'b00, 1'b0, 7'h09, 32'h0,        32'h00000055, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("lb0B",   1'b0, 2'b00, 1'b1, 7'h0B, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("sh0E",   1'b1, 2'b01, 1'b0, 7'h0E, 32'h00008001, 32'hFFFFFFDE, 1'b0, 4, 2, 1'b1, 5'd3, 32'h80015678);
    add("lh0E",   1'b0, 2'b01, 1'b1, 7'h0E, 32'h0,        32'hFFFF8001, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("lhu0E",  1'b0, 2'b01, 1'b0, 7'h0E, 32'h0,        32'h00008001, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("ill_ld", 1'b0, 2'b11, 1'b0, 7'h04, 32'h0,        32'h00008001, 1'b1, 1, 0, 1'b0, 5'd0, 32'h0);
    add("ill_st", 1'b1, 2'b11, 1'b0, 7'h08, 32'h0,        32'h00008001, 1'b1, 1, 0, 1'b0, 5'd0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add("lw05",   1'b0, 2'b10, 1'b0, 7'h05, 32'h0,        32'h00008001, 1'b1, 1, 0, 1'b0, 5'd0, 32'h0);
    add("sb00",   1'b1, 2'b00, 1'b0, 7'h00, 32'hFFFFFFAB, 32'h00008001, 1'b0, 4, 2, 1'b1, 5'd0, 32'h000000AB);
`else
    add("lw05",   1'b0, 2'b10, 1'b0, 7'h05, 32'h0,        32'h11112222, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("sb00",   1'b1, 2'b00, 1'b0, 7'h00, 32'hFFFFFFAB, 32'h11112222, 1'b0, 4, 2, 1'b1, 5'd0, 32'h000000AB);
`endif
    add("lh00",   1'b0, 2'b01, 1'b1, 7'h00, 32'h0,        32'h000000AB, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
    add("lb00",   1'b0, 2'b00, 1'b1, 7'h00, 32'h0,        32'hFFFFFFAB, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add("sh03",   1'b1, 2'b01, 1'b0, 7'h03, 32'hFFFF1234, 32'hFFFFFFAB, 1'b1, 1, 0, 1'b0, 5'd0, 32'h0);
    add("lw00",   1'b0, 2'b10, 1'b0, 7'h00, 32'h0,        32'h000000AB, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
`else
    add("sh03",   1'b1, 2'b01, 1'b0, 7'h03, 32'hFFFF1234, 32'hFFFFFFAB, 1'b0, 4, 2, 1'b1, 5'd0, 32'h123400AB);
    add("lw00",   1'b0, 2'b10, 1'b0, 7'h00, 32'h0,        32'h123400AB, 1'b0, 3, 1, 1'b0, 5'd0, 32'h0);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_ena", {31'd0, ram_ena}, 32'd0);
    chk("rst_ram_wena", {31'd0, ram_wena}, 32'd0);
    chk("rst_ram_addr", {27'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    preload = 1'b0;
    rst = 1'b0;

    // Vector table.
    foreach (vecs[i]) begin
      ena0 = ena_count;
      wr0  = wr_count;
      issue(vecs[i].we, vecs[i].size, vecs[i].sx, vecs[i].addr, vecs[i].wdata, lat);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_ena_cycles"}, ena_count - ena0, vecs[i].exp_ena);
      chk({vecs[i].name, "_writes"}, wr_count - wr0, {31'd0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) begin
        chk({vecs[i].name, "_waddr"}, {27'd0, last_waddr}, {27'd0, vecs[i].exp_waddr});
        chk({vecs[i].name, "_wdata"}, last_wdata, vecs[i].exp_wdata);
      end
    end

    // Reset asserted one cycle into the WR of a byte store to word 4.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    wr0 = wr_count; done0 = done_count;
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 7'h10; wdata = 32'h00000077;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstwr_in_wr", {31'd0, ram_wena}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_ena_low", {31'd0, ram_ena}, 32'd0);
    chk("rstwr_wena_low", {31'd0, ram_wena}, 32'd0);
    chk("rstwr_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstwr_no_done", done_count - done0, 32'd0);
    chk("rstwr_no_write", wr_count - wr0, 32'd0);
    chk("rstwr_rdata_cleared", rdata, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0, lat);
    chk("rstwr_lw10_lat", lat, 32'd3);
    chk("rstwr_lw10_rdata", rdata, 32'hCAFEF00D);

    // Request presented while a byte store is in RD must be dropped.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    done0 = done_count; a10 = addr1_count; wr0 = wr_count;
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 7'h18; wdata = 32'h00000099;
    @(posedge clk);
    #1;
    we = 1'b0; size = 2'b10; addr = 7'h04; wdata = 32'h0;
    chk("busy_ready_low", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_single_done", done_count - done0, 32'd1);
    chk("busy_no_addr1", addr1_count - a10, 32'd0);
    chk("busy_one_write", wr_count - wr0, 32'd1);
    chk("busy_ready_back", {31'd0, ready}, 32'd1);
    issue(1'b0, 2'b00, 1'b0, 7'h18, 32'h0, lat);
    chk("busy_lbu18_rdata", rdata, 32'h00000099);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
